turn_sequencer: RTL
===================

Name: turn_sequencer

Overview:
- Game controller between the debounced select/position inputs and the matrix driver.
- On each select it latches the cursor column and finds the lowest empty row. It then sequences a row-by-row falling-token animation and commits the token into the current player's grid.
- After the commit it runs a multi-cycle four-in-a-row check, then either alternates the turn or ends the game.
- Owns the green and blue 8x8 grids that the matrix driver displays.

Parameters:
- STEP_TICKS, 4, clock cycles the falling token spends on each row (must be >=1).
- WIN_LEN, 4, run length that wins.

Ports:
- clock  in  1  system clock (divided clock)
- rst  in  1  synchronous active-low reset
- select  in  1  one-cycle debounced drop request
- column  in  3  cursor column, 0 = leftmost
- green_grid  out  8x8  [r][c], r0 = top row; 1 = green token
- blue_grid  out  8x8  same indexing, blue tokens
- anim_valid  out  1  falling token is being shown
- anim_row  out  3  row of the falling token
- anim_col  out  3  column of the falling token
- player  out  1  side to move: 0 = green, 1 = blue
- busy  out  1  a drop or check is in progress
- reject  out  1  one-cycle pulse: the selected column is full
- winner  out  2  00 none, 01 green, 10 blue, 11 draw
- game_over  out  1  game has ended

Behaviour:
- Reset (rst low at a clock edge): both grids 0, player 0, winner 00, game_over 0, busy 0, anim_valid 0, anim_row 0, anim_col 0, reject 0, token count 0, state IDLE. Reset has priority in every state, including mid-fall and mid-check.
- IDLE: busy 0. If select=1, latch column into anim_col and go to FIND.
- FIND (1 cycle): target = largest r with green_grid[r][col]|blue_grid[r][col] == 0.
  - Column full (row 0 occupied): pulse reject for 1 cycle, return to IDLE. Player, grids and count are unchanged.
  - Otherwise go to FALL with anim_row = 0 and tick counter = 0.
- FALL: anim_valid = 1.
  - The tick counter counts 0..STEP_TICKS-1. At STEP_TICKS-1, if anim_row < target then anim_row increments and the counter clears; otherwise go to COMMIT.
  - FALL lasts (target+1)*STEP_TICKS cycles.
- COMMIT (1 cycle): set grid[target][col] in the current player's grid, increment the token count (7 bits, max 64), anim_valid = 0.
  - Grids change only here; the falling token is never written into a grid before COMMIT.
- CHECK (4 cycles, one direction per cycle): directions are horizontal (0,+1), vertical (+1,0), diagonal (+1,+1) and anti-diagonal (+1,-1).
  - run = 1 + consecutive same-player cells forward (up to WIN_LEN-1) + consecutive same-player cells backward (up to WIN_LEN-1).
  - Stepping stops at the grid edge; there is no wrap across column 7/0 or row 7/0.
  - Any run >= WIN_LEN sets a sticky win flag.
- RESULT (1 cycle):
  - Win: winner = 01 or 10 for the current player, go to OVER.
  - Else if count == 64: winner = 11, go to OVER. A win on the 64th token takes priority over the draw.
  - Else toggle player and go to IDLE.
- OVER: game_over = 1, busy = 0. select is ignored. Grids and winner hold until reset.
- busy = 1 in FIND, FALL, COMMIT, CHECK and RESULT.
  - select while busy or in OVER is dropped, not queued.
  - column changes after the latch do not affect the drop in progress.
- Latency from the select edge to IDLE/OVER: 1 + (target+1)*STEP_TICKS + 1 + 4 + 1 cycles.

Test Plan:
- Reset: hold rst=0 for 2 cycles, release -> grids all 0, player=0, winner=00, busy=0, anim_valid=0.
- Single drop (STEP_TICKS=2): select with column=3 -> anim_row steps 0..7 over 16 cycles; then green_grid[7][3]=1; busy high for exactly 23 cycles; player=1 afterwards.
- Vertical win: alternate drops into columns 0 (green) and 1 (blue), 7 drops total -> after the 7th, winner=01 and game_over=1. A further select leaves the grids unchanged.
- Full column: 8 drops into column 5, then a 9th select -> reject high for exactly 1 cycle; grids, player and count unchanged; busy returns to 0 two cycles after the select.
- Edge/no-wrap: green holds row 7 columns 6,7 and row 6 columns 0,1 -> winner stays 00. Green holds row 7 columns 4-7 -> winner=01.
- Mid-operation: pull rst low during FALL with anim_row=3 -> next edge: anim_valid=0, grids 0, player=0. A select during FALL with a different column does not alter anim_col.

Source files
------------

// File: rtl/turn_sequencer_if.sv
// Handshake and display bus between the game FSM, the debounced inputs and the matrix driver.
interface turn_sequencer_if;
  logic            i_select;
  logic [2:0]      i_column;
  logic [7:0][7:0] o_green_grid;
  logic [7:0][7:0] o_blue_grid;
  logic            o_anim_valid;
  logic [2:0]      o_anim_row;
  logic [2:0]      o_anim_col;
  logic            o_player;
  logic            o_busy;
  logic            o_reject;
  logic [1:0]      o_winner;
  logic            o_game_over;

  modport slave (
    input  i_select, i_column,
    output o_green_grid, o_blue_grid, o_anim_valid, o_anim_row, o_anim_col,
           o_player, o_busy, o_reject, o_winner, o_game_over
  );

  modport master (
    output i_select, i_column,
    input  o_green_grid, o_blue_grid, o_anim_valid, o_anim_row, o_anim_col,
           o_player, o_busy, o_reject, o_winner, o_game_over
  );
endinterface

// File: rtl/turn_sequencer.sv
// Four-in-a-row turn FSM: latch column, animate fall, commit, 4-cycle win check, result.
// Drop latency 1+(target+1)*STEP_TICKS+1+4+1 cycles; selects while busy or game over are dropped.
module turn_sequencer #(
  parameter int STEP_TICKS = 4,
  parameter int WIN_LEN    = 4
) (
  input  logic             i_clock,
  input  logic             i_rst,
  turn_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FIND, S_FALL, S_COMMIT, S_CHECK, S_RESULT, S_OVER
  } state_t;

  localparam int TW = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

  state_t          r_state;
  logic [7:0][7:0] r_green;
  logic [7:0][7:0] r_blue;
  logic            r_player;
  logic [1:0]      r_winner;
  logic            r_game_over;
  logic            r_busy;
  logic            r_anim_valid;
  logic [2:0]      r_anim_row;
  logic [2:0]      r_anim_col;
  logic            r_reject;
  logic [6:0]      r_count;
  logic [2:0]      r_target;
  logic [TW-1:0]   r_tick;
  logic [1:0]      r_dir;
  logic            r_win;

  logic [7:0]      w_occ;
  logic [2:0]      w_target;
  logic            w_full;
  logic [7:0][7:0] w_pg;
  int              w_run;
  logic            w_hit;

  always_comb begin
    w_target = 3'd0;
    for (int r = 0; r < 8; r++) begin
      w_occ[r] = r_green[r][r_anim_col] | r_blue[r][r_anim_col];
      if (!w_occ[r]) w_target = 3'(r);
    end
  end

  // Gravity keeps columns packed from the bottom, so row 0 occupied means full.
  assign w_full = w_occ[0];
  assign w_pg   = r_player ? r_blue : r_green;

  always_comb begin : check_run
    int   dr;
    int   dc;
    int   rr;
    int   cc;
    logic go;
    dr = 0;
    dc = 1;
    rr = 0;
    cc = 0;
    case (r_dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    w_run = 1;
    go    = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      rr = int'(r_target) + k * dr;
      cc = int'(r_anim_col) + k * dc;
      if (go && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && w_pg[rr[2:0]][cc[2:0]])
        w_run = w_run + 1;
      else
        go = 1'b0;
    end
    go = 1'b1;
    for (int k = 1; k < WIN_LEN; k++) begin
      rr = int'(r_target) - k * dr;
      cc = int'(r_anim_col) - k * dc;
      if (go && rr >= 0 && rr < 8 && cc >= 0 && cc < 8 && w_pg[rr[2:0]][cc[2:0]])
        w_run = w_run + 1;
      else
        go = 1'b0;
    end
  end

  assign w_hit = (w_run >= WIN_LEN);

  always_ff @(posedge i_clock) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_green      <= '0;
      r_blue       <= '0;
      r_player     <= 1'b0;
      r_winner     <= 2'b00;
      r_game_over  <= 1'b0;
      r_busy       <= 1'b0;
      r_anim_valid <= 1'b0;
      r_anim_row   <= 3'd0;
      r_anim_col   <= 3'd0;
      r_reject     <= 1'b0;
      r_count      <= 7'd0;
      r_target     <= 3'd0;
      r_tick       <= '0;
      r_dir        <= 2'd0;
      r_win        <= 1'b0;
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_select) begin
            r_anim_col <= bus.i_column;
            r_busy     <= 1'b1;
            r_state    <= S_FIND;
          end
        end
        S_FIND: begin
          if (w_full) begin
            r_reject <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_target     <= w_target;
            r_anim_row   <= 3'd0;
            r_tick       <= '0;
            r_anim_valid <= 1'b1;
            r_state      <= S_FALL;
          end
        end
        S_FALL: begin
          if (r_tick == TW'(STEP_TICKS - 1)) begin
            if (r_anim_row < r_target) begin
              r_anim_row <= r_anim_row + 3'd1;
              r_tick     <= '0;
            end else begin
              r_anim_valid <= 1'b0;
              r_state      <= S_COMMIT;
            end
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        S_COMMIT: begin
          if (r_player) r_blue[r_target][r_anim_col]  <= 1'b1;
          else          r_green[r_target][r_anim_col] <= 1'b1;
          r_count <= r_count + 7'd1;
          r_dir   <= 2'd0;
          r_win   <= 1'b0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_hit) r_win <= 1'b1;
          r_dir <= r_dir + 2'd1;
          if (r_dir == 2'd3) r_state <= S_RESULT;
        end
        S_RESULT: begin
          r_busy <= 1'b0;
          if (r_win) begin
            r_winner    <= r_player ? 2'b10 : 2'b01;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else if (r_count == 7'd64) begin
            r_winner    <= 2'b11;
            r_game_over <= 1'b1;
            r_state     <= S_OVER;
          end else begin
            r_player <= ~r_player;
            r_state  <= S_IDLE;
          end
        end
        S_OVER:  r_state <= S_OVER;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_green_grid = r_green;
  assign bus.o_blue_grid  = r_blue;
  assign bus.o_anim_valid = r_anim_valid;
  assign bus.o_anim_row   = r_anim_row;
  assign bus.o_anim_col   = r_anim_col;
  assign bus.o_player     = r_player;
  assign bus.o_busy       = r_busy;
  assign bus.o_reject     = r_reject;
  assign bus.o_winner     = r_winner;
  assign bus.o_game_over  = r_game_over;

endmodule
